vector_addsub_seq: RTL and testbench

Multi-beat, parametrised vector adder/subtractor for the vector execution unit. It processes a VLEN-bit operand pair DATAPATH_W bits per cycle, with element widths (SEW) from 8 bits to VLEN bits. Element carries propagate across beat boundaries, carry-in/out is per element, and valid/ready handshakes sit on both sides. It replaces the single-cycle 256-bit add/sub, which has fixed width and no flow control.

---
 rtl/vector_processor_pkg.sv | 39 +++
 rtl/vaddsub_chunk.sv | 47 ++++
 rtl/vector_addsub_seq.sv | 215 +++++++++++++++++++++
 tb/tb_vector_addsub_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_processor_pkg.sv
// Shared types for the vector add/sub unit: SEW codes, FSM states, element sizing.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a. Optional SAT state exists only when VECTOR_ADDSUB_SAT_EN is defined.
package vector_processor_pkg;

   typedef enum logic [2:0] {
      SEW_8    = 3'b000,
      SEW_16   = 3'b001,
      SEW_32   = 3'b010,
      SEW_64   = 3'b011,
      SEW_128  = 3'b100,
      SEW_256  = 3'b101,
      SEW_RSV6 = 3'b110,
      SEW_RSV7 = 3'b111
   } sew_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
`ifdef VECTOR_ADDSUB_SAT_EN
      ST_SAT  = 2'd2,
`endif
      ST_DONE = 2'd3
   } state_e;

   // Element size in bytes for a SEW code; 0 flags a reserved code.
   function automatic logic [5:0] sew_bytes(input sew_e sew);
      case (sew)
         SEW_8:   sew_bytes = 6'd1;
         SEW_16:  sew_bytes = 6'd2;
         SEW_32:  sew_bytes = 6'd4;
         SEW_64:  sew_bytes = 6'd8;
         SEW_128: sew_bytes = 6'd16;
         SEW_256: sew_bytes = 6'd32;
         default: sew_bytes = 6'd0;
      endcase
   endfunction

endpackage

// File: rtl/vaddsub_chunk.sv
// One DATAPATH_W slice of the byte-wise add/sub carry chain, cut at element LSB bytes.
// Latency: purely combinational.
// Backpressure: none; the caller sequences beats.
module vaddsub_chunk #(
   parameter int DATAPATH_W = 64
) (
   input  logic [DATAPATH_W-1:0]   a_i,
   input  logic [DATAPATH_W-1:0]   b_i,
   input  logic                    op_i,
   input  logic [DATAPATH_W/8-1:0] cin_bytes_i,
   input  logic [DATAPATH_W/8-1:0] lsb_mask_i,
   input  logic [DATAPATH_W/8-1:0] msb_mask_i,
   input  logic                    chunk_cin_i,
   output logic [DATAPATH_W-1:0]   sum_o,
   output logic [DATAPATH_W/8-1:0] cout_bytes_o,
   output logic                    chunk_cout_o
);
   localparam int NB = DATAPATH_W / 8;

   logic [NB-1:0] byte_c;
   logic          chain;
   logic          cin_b;
   logic [8:0]    tmp;

   // Ripple through bytes; element LSB bytes restart from the external carry/borrow
   always_comb begin
      byte_c = '0;
      sum_o  = '0;
      chain  = chunk_cin_i;
      cin_b  = 1'b0;
      tmp    = '0;
      for (int i = 0; i < NB; i++) begin
         cin_b = lsb_mask_i[i] ? cin_bytes_i[i] : chain;
         if (op_i) begin
            tmp = {1'b0, a_i[i*8 +: 8]} + {1'b0, b_i[i*8 +: 8]} + {8'd0, cin_b};
         end else begin
            tmp = {1'b0, a_i[i*8 +: 8]} - {1'b0, b_i[i*8 +: 8]} - {8'd0, cin_b};
         end
         sum_o[i*8 +: 8] = tmp[7:0];
         byte_c[i]       = tmp[8];
         chain           = tmp[8];
      end
      cout_bytes_o = byte_c & msb_mask_i;
      chunk_cout_o = chain;
   end

endmodule

// File: rtl/vector_addsub_seq.sv
// Multi-beat VLEN add/sub, DATAPATH_W bits per beat, SEW 8..VLEN; optional VECTOR_ADDSUB_SAT_EN.
// Latency: out_valid_o rises NBEATS cycles after accept (NBEATS+1 with a saturating request).
// Backpressure: result held in DONE until out_ready_i; no new accept until back in IDLE.
module vector_addsub_seq
   import vector_processor_pkg::*;
#(
   parameter int VLEN       = 256,
   parameter int DATAPATH_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [VLEN-1:0]   a_i,
   input  logic [VLEN-1:0]   b_i,
   input  logic [2:0]        sew_i,
   input  logic              op_i,
   input  logic [VLEN/8-1:0] carry_i,
`ifdef VECTOR_ADDSUB_SAT_EN
   input  logic              sat_i,
`endif
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [VLEN-1:0]   result_o,
   output logic [VLEN/8-1:0] carry_o,
   output logic              err_o,
   output logic              busy_o
);
   localparam int NBEATS = VLEN / DATAPATH_W;
   localparam int NBYTES = VLEN / 8;
   localparam int DBYTES = DATAPATH_W / 8;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   state_e                              state_q, state_d;
   logic [NBEATS-1:0][DATAPATH_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [NBEATS-1:0][DBYTES-1:0]       cin_q, cin_d, cout_q, cout_d;
   sew_e                                sew_q, sew_d;
   logic                                op_q, op_d;
   logic [BW-1:0]                       beat_q, beat_d;
   logic                                cbeat_q, cbeat_d;
   logic                                err_q, err_d;
   logic                                out_valid_q, out_valid_d;
   logic                                busy_q, busy_d;
`ifdef VECTOR_ADDSUB_SAT_EN
   logic                                sat_q, sat_d;
`endif

   logic [5:0]             nb_in;
   logic                   sew_legal;
   logic [31:0]            eb_m1;
   logic [DBYTES-1:0]      lsb_mask, msb_mask;
   logic [DATAPATH_W-1:0]  chunk_sum;
   logic [DBYTES-1:0]      chunk_cout_bytes;
   logic                   chunk_cout;

   assign in_ready_o  = rst_ni && (state_q == ST_IDLE);
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign result_o    = res_q;
   assign carry_o     = cout_q;
   assign err_o       = err_q;

   // Legality of the incoming SEW: reserved code or element wider than the vector
   always_comb begin
      nb_in     = sew_bytes(sew_e'(sew_i));
      sew_legal = (nb_in != 6'd0) && ({26'd0, nb_in} <= 32'(NBYTES));
   end

   // Element boundary masks for the bytes of the current beat
   always_comb begin
      eb_m1    = {26'd0, sew_bytes(sew_q)} - 32'd1;
      lsb_mask = '0;
      msb_mask = '0;
      for (int i = 0; i < DBYTES; i++) begin
         lsb_mask[i] = (((32'(beat_q) * DBYTES) + 32'(i)) & eb_m1) == 32'd0;
         msb_mask[i] = (((32'(beat_q) * DBYTES) + 32'(i)) & eb_m1) == eb_m1;
      end
   end

   vaddsub_chunk #(.DATAPATH_W(DATAPATH_W)) u_chunk (
      .a_i          (a_q[beat_q]),
      .b_i          (b_q[beat_q]),
      .op_i         (op_q),
      .cin_bytes_i  (cin_q[beat_q]),
      .lsb_mask_i   (lsb_mask),
      .msb_mask_i   (msb_mask),
      .chunk_cin_i  (cbeat_q),
      .sum_o        (chunk_sum),
      .cout_bytes_o (chunk_cout_bytes),
      .chunk_cout_o (chunk_cout)
   );

`ifdef VECTOR_ADDSUB_SAT_EN
   logic [NBYTES-1:0][7:0] res_sat;
   logic [NBYTES-1:0]      cout_flat;
   logic                   elem_hit;

   // Clamp each element whose final carry/borrow is set, scanning MSB byte downwards
   always_comb begin
      res_sat   = res_q;
      cout_flat = cout_q;
      elem_hit  = 1'b0;
      for (int j = NBYTES - 1; j >= 0; j--) begin
         if ((32'(j) & eb_m1) == eb_m1) elem_hit = cout_flat[j];
         if (elem_hit) res_sat[j] = op_q ? 8'hFF : 8'h00;
      end
   end
`endif

   // FSM next-state, operand capture and per-beat result accumulation
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sew_d   = sew_q;
      op_d    = op_q;
      cin_d   = cin_q;
      beat_d  = beat_q;
      cbeat_d = cbeat_q;
      res_d   = res_q;
      cout_d  = cout_q;
      err_d   = err_q;
`ifdef VECTOR_ADDSUB_SAT_EN
      sat_d   = sat_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               sew_d   = sew_e'(sew_i);
               op_d    = op_i;
               cin_d   = carry_i;
               beat_d  = '0;
               cbeat_d = 1'b0;
               res_d   = '0;
               cout_d  = '0;
               err_d   = !sew_legal;
`ifdef VECTOR_ADDSUB_SAT_EN
               sat_d   = sat_i;
`endif
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // An illegal SEW still burns its beats but leaves result/carry at zero
            if (!err_q) begin
               res_d[beat_q]  = chunk_sum;
               cout_d[beat_q] = chunk_cout_bytes;
            end
            cbeat_d = chunk_cout;
            beat_d  = beat_q + 1'b1;
            if (beat_q == BW'(NBEATS - 1)) begin
`ifdef VECTOR_ADDSUB_SAT_EN
               state_d = sat_q ? ST_SAT : ST_DONE;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef VECTOR_ADDSUB_SAT_EN
         ST_SAT: begin
            res_d   = res_sat;
            state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset drops any in-flight transaction
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sew_q       <= SEW_8;
         op_q        <= 1'b0;
         cin_q       <= '0;
         beat_q      <= '0;
         cbeat_q     <= 1'b0;
         res_q       <= '0;
         cout_q      <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef VECTOR_ADDSUB_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sew_q       <= sew_d;
         op_q        <= op_d;
         cin_q       <= cin_d;
         beat_q      <= beat_d;
         cbeat_q     <= cbeat_d;
         res_q       <= res_d;
         cout_q      <= cout_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef VECTOR_ADDSUB_SAT_EN
         sat_q       <= sat_d;
`endif
      end
   end

endmodule

// File: tb/tb_vector_addsub_seq.sv
// Scoreboard bench for vector_addsub_seq: element-level reference model vs DUT.
// Latency and hold-under-backpressure are checked alongside the data.
// Random out_ready_i stalls exercise the DONE hold path.
module tb_vector_addsub_seq;
   localparam int VLEN   = 256;
   localparam int DW     = 64;
   localparam int NBEATS = VLEN / DW;
   localparam int NBYTES = VLEN / 8;

   typedef struct {
      logic [VLEN-1:0]   res;
      logic [NBYTES-1:0] car;
      logic              err;
      int                rise;
   } exp_t;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              in_valid;
   logic              in_ready_o;
   logic [VLEN-1:0]   a, b;
   logic [2:0]        sew;
   logic              op;
   logic [NBYTES-1:0] cin;
   logic              sat;
   logic              out_valid_o;
   logic              out_ready;
   logic [VLEN-1:0]   result_o;
   logic [NBYTES-1:0] carry_o;
   logic              err_o;
   logic              busy_o;

   int   total_cnt  = 0;
   int   passed_cnt = 0;
   int   cyc        = 0;
   int   rdy_mode   = 0;
   logic prev_vld   = 1'b0;
   exp_t sbq[$];

   vector_addsub_seq #(.VLEN(VLEN), .DATAPATH_W(DW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready_o),
      .a_i         (a),
      .b_i         (b),
      .sew_i       (sew),
      .op_i        (op),
      .carry_i     (cin),
`ifdef VECTOR_ADDSUB_SAT_EN
      .sat_i       (sat),
`endif
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready),
      .result_o    (result_o),
      .carry_o     (carry_o),
      .err_o       (err_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
      total_cnt++;
      if (act === req) passed_cnt++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   // Element-level reference: each element is an independent SEW-bit add/sub with its own carry in.
   function automatic exp_t model(input logic [VLEN-1:0] ma, input logic [VLEN-1:0] mb,
                                  input logic [2:0] ms, input logic mop,
                                  input logic [NBYTES-1:0] mc, input logic msat);
      exp_t e;
      int ew;
      logic [VLEN:0] ea, eb, es, mask, ci;
      logic c;
      e.res = '0; e.car = '0; e.err = 1'b0; e.rise = 0;
      if (ms > 3'd5) begin
         e.err = 1'b1;
         return e;
      end
      ew = 8 << ms;
      if (ew > VLEN) begin
         e.err = 1'b1;
         return e;
      end
      mask = ({{VLEN{1'b0}}, 1'b1} << ew) - 1;
      for (int k = 0; k < VLEN / ew; k++) begin
         ea = {1'b0, ma >> (k * ew)} & mask;
         eb = {1'b0, mb >> (k * ew)} & mask;
         ci = '0;
         ci[0] = mc[k * (ew / 8)];
         if (mop) begin
            es = ea + eb + ci;
            c  = es[ew];
         end else begin
            c  = (ea < eb + ci);
            es = ea - eb - ci;
         end
         es = es & mask;
         if (msat && c) es = mop ? mask : '0;
         e.res = e.res | (es[VLEN-1:0] << (k * ew));
         if (c) e.car[(k + 1) * (ew / 8) - 1] = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [VLEN-1:0] rand_vec();
      logic [VLEN-1:0] v;
      for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // out_ready driver: 0 = always ready, 1 = random stalls, 2 = stalled
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk_i); #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: latency on each rising out_valid_o, data on each handshake
   always @(negedge clk_i) begin
      exp_t e;
      if (out_valid_o && !prev_vld) begin
         chk("spurious_valid", VLEN'(sbq.size() == 0), '0);
         if (sbq.size() != 0) chk("latency", VLEN'(cyc), VLEN'(sbq[0].rise));
      end
      if (out_valid_o && out_ready && sbq.size() != 0) begin
         e = sbq.pop_front();
         chk("result", result_o, e.res);
         chk("carry", VLEN'(carry_o), VLEN'(e.car));
         chk("err", VLEN'(err_o), VLEN'(e.err));
      end
      prev_vld = out_valid_o;
   end

   task automatic send(input logic [VLEN-1:0] ta, input logic [VLEN-1:0] tb2, input logic [2:0] ts,
                       input logic top, input logic [NBYTES-1:0] tc, input logic tsat, input bit track);
      exp_t e;
      int n;
      @(posedge clk_i); #1;
      a = ta; b = tb2; sew = ts; op = top; cin = tc; sat = tsat; in_valid = 1'b1;
      n = 0;
      while (!in_ready_o && n < 200) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("accept", VLEN'(in_ready_o), VLEN'(1));
      if (in_ready_o && track) begin
         e = model(ta, tb2, ts, top, tc, tsat);
         e.rise = cyc + 1 + NBEATS + (tsat ? 1 : 0);
         sbq.push_back(e);
      end
      @(posedge clk_i); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || busy_o) && n < 1000) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("drain_queue", VLEN'(sbq.size()), '0);
      chk("drain_busy", VLEN'(busy_o), '0);
   endtask

   initial begin
      logic [VLEN-1:0] ones, bytes01, w32one, w16a, w16b;
      int n;
      logic s;
      rst_ni = 1'b0; in_valid = 1'b0; a = '0; b = '0; sew = 3'd0; op = 1'b0; cin = '0; sat = 1'b0;
      ones    = '1;
      bytes01 = {NBYTES{8'h01}};
      w32one  = {(VLEN/32){32'h0000_0001}};
      w16a    = rand_vec();
      w16b    = rand_vec();

      repeat (2) @(posedge clk_i); #1;
      chk("rst_result", result_o, '0);
      chk("rst_carry", VLEN'(carry_o), '0);
      chk("rst_err", VLEN'(err_o), '0);
      chk("rst_valid", VLEN'(out_valid_o), '0);
      chk("rst_busy", VLEN'(busy_o), '0);
      chk("rst_ready", VLEN'(in_ready_o), '0);
      rst_ni = 1'b1; #1;
      chk("ready_after_rst", VLEN'(in_ready_o), VLEN'(1));

      // SEW8 byte wrap, SEW256 full carry ripple, SEW32 borrow with carry_i[0]
      send(ones, bytes01, 3'd0, 1'b1, '0, 1'b0, 1'b1);
      send(ones, VLEN'(1), 3'd5, 1'b1, '0, 1'b0, 1'b1);
      send('0, w32one, 3'd2, 1'b0, NBYTES'(1), 1'b0, 1'b1);
      chk("busy_in_busy", VLEN'(busy_o), VLEN'(1));
      chk("ready_in_busy", VLEN'(in_ready_o), '0);
      drain();

      // Backpressure: results held in DONE, new requests ignored
      rdy_mode = 2;
      send(rand_vec(), rand_vec(), 3'd3, 1'b1, NBYTES'($urandom), 1'b0, 1'b1);
      n = 0;
      while (!out_valid_o && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("bp_reach_done", VLEN'(out_valid_o), VLEN'(1));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         in_valid = 1'b1; a = rand_vec(); sew = 3'd0;
         chk("bp_ready", VLEN'(in_ready_o), '0);
         chk("bp_valid", VLEN'(out_valid_o), VLEN'(1));
         if (sbq.size() != 0) begin
            chk("bp_hold_result", result_o, sbq[0].res);
            chk("bp_hold_carry", VLEN'(carry_o), VLEN'(sbq[0].car));
         end
      end
      @(posedge clk_i); #1;
      in_valid = 1'b0;
      rdy_mode = 0;
      drain();
      send(rand_vec(), rand_vec(), 3'd1, 1'b0, NBYTES'($urandom), 1'b0, 1'b1);
      drain();

      // Reserved SEW, then a legal SEW16 request
      send(rand_vec(), rand_vec(), 3'b110, 1'b1, '1, 1'b0, 1'b1);
      send(w16a, w16b, 3'd1, 1'b1, NBYTES'($urandom), 1'b0, 1'b1);
      drain();

      // Reset during beat 2 discards the transaction
      send(rand_vec(), rand_vec(), 3'd3, 1'b1, '0, 1'b0, 1'b0);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b0; #1;
      chk("midrst_result", result_o, '0);
      chk("midrst_carry", VLEN'(carry_o), '0);
      chk("midrst_valid", VLEN'(out_valid_o), '0);
      chk("midrst_busy", VLEN'(busy_o), '0);
      chk("midrst_ready", VLEN'(in_ready_o), '0);
      repeat (2) @(posedge clk_i); #1;
      rst_ni = 1'b1; #1;
      chk("ready_after_midrst", VLEN'(in_ready_o), VLEN'(1));
      send(rand_vec(), rand_vec(), 3'd3, 1'b1, NBYTES'($urandom), 1'b0, 1'b1);
      drain();

`ifdef VECTOR_ADDSUB_SAT_EN
      send({NBYTES{8'hF0}}, {NBYTES{8'h20}}, 3'd0, 1'b1, '0, 1'b1, 1'b1);
      send({NBYTES{8'h10}}, {NBYTES{8'h20}}, 3'd0, 1'b0, '0, 1'b1, 1'b1);
      drain();
`endif

      // Randomised traffic with random consumer stalls
      rdy_mode = 1;
      for (int t = 0; t < 40; t++) begin
`ifdef VECTOR_ADDSUB_SAT_EN
         s = $urandom_range(0, 1) == 1;
`else
         s = 1'b0;
`endif
         send(rand_vec(), rand_vec(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              NBYTES'($urandom), s, 1'b1);
      end
      rdy_mode = 0;
      drain();
      repeat (10) @(posedge clk_i);
      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
